// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: memory access size, MEM-stage FSM states, register index width.
package pipe_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and data memory (slave).
interface memory_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [3:0]        memBe;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              memAck;

    modport master (
        output memReq, memWe, memAddr, memBe, memWData,
        input  memRData, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memBe, memWData,
        output memRData, memAck
    );

endinterface

// File: rtl/load_store_align.sv
// Lane steering for the MEM stage: byte enables, store replication, load extract/extend, misalignment.
// Purely combinational, zero latency, no handshake.
module load_store_align
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size_i,
    input  logic [1:0]        lo_i,
    input  logic              uns_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              misalign_o
);
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata_i[{lo_i, 3'b000} +: 8];
    assign rhalf = rdata_i[{lo_i[1], 4'b0000} +: 16];

    always_comb begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
        misalign_o = 1'b0;
        case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << lo_i;
                wdata_o = {(DATA_W/8){wdata_i[7:0]}};
                rdata_o = uns_i ? {{(DATA_W-8){1'b0}}, rbyte} : {{(DATA_W-8){rbyte[7]}}, rbyte};
            end
            MEM_HALF: begin
                be_o       = 4'b0011 << lo_i;
                wdata_o    = {(DATA_W/16){wdata_i[15:0]}};
                rdata_o    = uns_i ? {{(DATA_W-16){1'b0}}, rhalf} : {{(DATA_W-16){rhalf[15]}}, rhalf};
                misalign_o = lo_i[0];
            end
            // Word and the reserved encoding both behave as a full-word access.
            default: misalign_o = (lo_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues data-memory accesses, steers lanes, registers MEM/WB; zero-stall on same-cycle ack.
// Holds upstream with stallM until ack or timeout; misaligned accesses become W bubbles without stalling.
module memory_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 memToRegM,
    input  logic                 regWriteM,
    input  logic                 memWriteM,
    input  logic [1:0]           memSizeM,
    input  logic                 loadUnsignedM,
    input  logic [DATA_W-1:0]    ALUOutM,
    input  logic [DATA_W-1:0]    writeDataM,
    input  logic [REG_IDX_W-1:0] writeRegM,
    memory_stage_if.master       mem,
    output logic                 stallM,
    output logic                 alignErrM,
    output logic                 memErr,
    output logic                 memToRegW,
    output logic                 regWriteW,
    output logic [DATA_W-1:0]    readDataW,
    output logic [DATA_W-1:0]    ALUOutW,
    output logic [REG_IDX_W-1:0] writeRegW
);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t                 state_q;
    logic                   we_q, uns_q, err_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [3:0]             be_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [1:0]             size_q, lo_q;
    logic [9:0]             cnt_q;
    logic                   memToRegW_q, regWriteW_q;
    logic [DATA_W-1:0]      readDataW_q, ALUOutW_q;
    logic [REG_IDX_W-1:0]   writeRegW_q;

    logic                   idle, waiting, isAccess, startReq, alignBad, toHit, loadOk, misalign;
    logic [1:0]             selSize, selLo;
    logic                   selUns;
    logic [3:0]             beNew;
    logic [DATA_W-1:0]      wdataNew, rdataExt, readData_d;
    logic [ADDR_W-1:0]      addrNew;

    // Reset gates everything combinational so an abandoned access drops memReq/stallM at once.
    assign idle     = rstN && (state_q == IDLE);
    assign waiting  = rstN && (state_q == WAIT);
    assign isAccess = memToRegM || memWriteM;
    assign addrNew  = {ALUOutM[ADDR_W-1:2], 2'b00};

    assign selSize = waiting ? size_q : memSizeM;
    assign selLo   = waiting ? lo_q   : ALUOutM[1:0];
    assign selUns  = waiting ? uns_q  : loadUnsignedM;

    load_store_align #(.DATA_W(DATA_W)) u_align (
        .size_i     (selSize),
        .lo_i       (selLo),
        .uns_i      (selUns),
        .wdata_i    (writeDataM),
        .rdata_i    (mem.memRData),
        .be_o       (beNew),
        .wdata_o    (wdataNew),
        .rdata_o    (rdataExt),
        .misalign_o (misalign)
    );

    assign alignBad   = idle && isAccess && misalign;
    assign startReq   = idle && isAccess && !misalign;
    assign toHit      = waiting && !mem.memAck && (cnt_q == TO_LAST);
    assign stallM     = (startReq && !mem.memAck) || (waiting && !mem.memAck && !toHit);
    assign loadOk     = memToRegM && !memWriteM && !alignBad;
    assign readData_d = toHit ? '0 : rdataExt;

    assign mem.memReq   = startReq || waiting;
    assign mem.memWe    = waiting ? we_q    : (startReq && memWriteM);
    assign mem.memAddr  = waiting ? addr_q  : (startReq ? addrNew  : '0);
    assign mem.memBe    = waiting ? be_q    : (startReq ? beNew    : 4'b0000);
    assign mem.memWData = waiting ? wdata_q : (startReq ? wdataNew : '0);

    assign alignErrM = alignBad;
    assign memErr    = err_q;
    assign memToRegW = memToRegW_q;
    assign regWriteW = regWriteW_q;
    assign readDataW = readDataW_q;
    assign ALUOutW   = ALUOutW_q;
    assign writeRegW = writeRegW_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            size_q      <= 2'b00;
            lo_q        <= 2'b00;
            uns_q       <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            memToRegW_q <= 1'b0;
            regWriteW_q <= 1'b0;
            readDataW_q <= '0;
            ALUOutW_q   <= '0;
            writeRegW_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startReq && !mem.memAck) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                        we_q    <= memWriteM;
                        addr_q  <= addrNew;
                        be_q    <= beNew;
                        wdata_q <= wdataNew;
                        size_q  <= memSizeM;
                        lo_q    <= ALUOutM[1:0];
                        uns_q   <= loadUnsignedM;
                    end
                end
                WAIT: begin
                    if (mem.memAck || toHit) begin
                        state_q <= IDLE;
                        if (toHit) err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (stallM) begin
                memToRegW_q <= 1'b0;
                regWriteW_q <= 1'b0;
            end else begin
                memToRegW_q <= loadOk;
                regWriteW_q <= regWriteM && !alignBad;
                ALUOutW_q   <= ALUOutM;
                writeRegW_q <= writeRegM;
                if (loadOk) readDataW_q <= readData_d;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage against a byte-level reference model.
module tb_memory_stage;
    import pipe_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        memToRegM, regWriteM, memWriteM, loadUnsignedM;
    logic [1:0]  memSizeM;
    logic [31:0] ALUOutM, writeDataM;
    logic [4:0]  writeRegM;
    logic        stallM, alignErrM, memErr, memToRegW, regWriteW;
    logic [31:0] readDataW, ALUOutW;
    logic [4:0]  writeRegW;

    memory_stage_if #(.DATA_W(32), .ADDR_W(32)) mem_bus();

    memory_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rstN(rstN),
        .memToRegM(memToRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .memSizeM(memSizeM), .loadUnsignedM(loadUnsignedM), .ALUOutM(ALUOutM),
        .writeDataM(writeDataM), .writeRegM(writeRegM), .mem(mem_bus),
        .stallM(stallM), .alignErrM(alignErrM), .memErr(memErr),
        .memToRegW(memToRegW), .regWriteW(regWriteW), .readDataW(readDataW),
        .ALUOutW(ALUOutW), .writeRegW(writeRegW)
    );

    typedef struct { logic rw; logic m2r; logic [31:0] rd; logic [31:0] alu; logic [4:0] wr; logic err; } wexp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    wexp_t prevW;
    logic  errModel;
    logic  active = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // W-side monitor: one expected MEM/WB snapshot per clock edge.
    always @(posedge clk) begin : mon_w
        wexp_t e;
        if (active && rstN) begin
            @(negedge clk);
            if (wq.size() == 0) begin
                checks++; failures++;
                $display("FAIL w_queue_empty actual=update required=expectation t=%0t", $time);
            end else begin
                e = wq.pop_front();
                chk("regWriteW", 32'(regWriteW), 32'(e.rw));
                chk("memToRegW", 32'(memToRegW), 32'(e.m2r));
                chk("readDataW", readDataW, e.rd);
                chk("ALUOutW",   ALUOutW,   e.alu);
                chk("writeRegW", 32'(writeRegW), 32'(e.wr));
                chk("memErr",    32'(memErr), 32'(e.err));
            end
        end
    end

    // Bus monitor: every request cycle must match the oldest outstanding request.
    always @(negedge clk) begin : mon_b
        bexp_t b;
        if (active && mem_bus.memReq) begin
            if (bq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_memReq actual=1 required=0 t=%0t", $time);
            end else begin
                b = bq[0];
                chk("memAddr", mem_bus.memAddr, b.addr);
                chk("memBe",   32'(mem_bus.memBe), 32'(b.be));
                chk("memWe",   32'(mem_bus.memWe), 32'(b.we));
                if (b.we) chk("memWData", mem_bus.memWData, b.wd);
                if (!stallM) bq.delete(0);
            end
        end
    end

    task automatic run_instr(input logic ld, input logic st, input logic rw, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input logic [4:0] wr, input int d);
        int nb, n;
        logic acc, mis, to, isLoad;
        logic [31:0] mask, v, wrep;
        wexp_t e;
        bexp_t b;
        acc    = ld || st;
        nb     = (sz == MEM_BYTE) ? 1 : (sz == MEM_HALF) ? 2 : 4;
        mis    = acc && ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00));
        n      = (!acc || mis) ? 0 : ((d < TO) ? d : TO);
        to     = acc && !mis && (d > TO);
        isLoad = ld && !st && !mis;
        if (acc && !mis) begin
            for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % nb) +: 8];
            b.we   = st;
            b.addr = addr & ~32'd3;
            b.be   = 4'(((1 << nb) - 1) << addr[1:0]);
            b.wd   = wrep;
            bq.push_back(b);
        end
        for (int k = 0; k < n; k++) begin
            e = prevW; e.rw = 1'b0; e.m2r = 1'b0; e.err = errModel;
            wq.push_back(e); prevW = e;
        end
        if (to) errModel = 1'b1;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        v = (rd >> (8*addr[1:0])) & mask;
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.rw  = rw && !mis;
        e.m2r = isLoad;
        e.alu = addr;
        e.wr  = wr;
        e.err = errModel;
        e.rd  = isLoad ? (to ? 32'd0 : v) : prevW.rd;
        wq.push_back(e); prevW = e;

        memToRegM = ld; memWriteM = st; regWriteM = rw; memSizeM = sz; loadUnsignedM = uns;
        ALUOutM = addr; writeDataM = wd; writeRegM = wr; mem_bus.memRData = rd;
        for (int c = 0; c <= n; c++) begin
            mem_bus.memAck = (acc && !mis) ? (c == d) : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stallM",    32'(stallM),    32'(c < n));
            chk("alignErrM", 32'(alignErrM), 32'((c == 0) && mis));
            @(posedge clk); #1;
        end
        mem_bus.memAck = 1'b0;
    endtask

    task automatic idle_inputs();
        memToRegM = 0; memWriteM = 0; regWriteM = 0; memSizeM = 0; loadUnsignedM = 0;
        ALUOutM = 0; writeDataM = 0; writeRegM = 0;
        mem_bus.memRData = 0; mem_bus.memAck = 0;
    endtask

    initial begin
        int kind, sz;
        logic [31:0] a;
        idle_inputs();
        prevW = '{default: 0};
        errModel = 1'b0;
        rstN = 1'b0;
        memToRegM = 1'b1; memSizeM = MEM_WORD; ALUOutM = 32'h100; regWriteM = 1'b1;
        #12;
        chk("rst_memReq", 32'(mem_bus.memReq), 32'd0);
        chk("rst_stallM", 32'(stallM), 32'd0);
        ALUOutM = 32'h101;
        #1;
        chk("rst_alignErrM", 32'(alignErrM), 32'd0);
        chk("rst_memErr", 32'(memErr), 32'd0);
        chk("rst_regWriteW", 32'(regWriteW), 32'd0);
        chk("rst_readDataW", readDataW, 32'd0);
        idle_inputs();
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        active = 1'b1;

        run_instr(1, 0, 1, MEM_WORD, 0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 0);
        run_instr(1, 0, 1, MEM_BYTE, 0, 32'h103, 32'h0, 32'h80000000, 5'd4, 3);
        run_instr(0, 1, 0, MEM_HALF, 0, 32'h202, 32'h0000ABCD, 32'h0, 5'd5, 1);
        run_instr(1, 0, 1, MEM_WORD, 0, 32'h101, 32'h0, 32'h12345678, 5'd6, 0);
        run_instr(1, 0, 1, MEM_WORD, 0, 32'h104, 32'h0, 32'h55555555, 5'd7, 100);
        run_instr(1, 0, 1, MEM_HALF, 1, 32'h106, 32'h0, 32'h8001_7FFF, 5'd8, 4);
        run_instr(0, 0, 1, MEM_WORD, 0, 32'h0AA, 32'h0, 32'h0, 5'd9, 0);

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            sz   = $urandom_range(0, 3);
            a    = {20'h0, 12'($urandom)};
            if ($urandom_range(0, 3) != 0) a = (sz == 0) ? a : (sz == 1) ? (a & ~32'd1) : (a & ~32'd3);
            run_instr(kind == 1 || kind == 3, kind >= 2, 1'($urandom), 2'(sz), 1'($urandom),
                      a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 5));
        end

        // Asynchronous reset in the middle of a pending access.
        active = 1'b0;
        memToRegM = 1; memWriteM = 0; regWriteM = 1; memSizeM = MEM_WORD; ALUOutM = 32'h300;
        mem_bus.memAck = 0;
        @(negedge clk);
        chk("pre_rst_stallM", 32'(stallM), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        chk("arst_memReq", 32'(mem_bus.memReq), 32'd0);
        chk("arst_stallM", 32'(stallM), 32'd0);
        chk("arst_regWriteW", 32'(regWriteW), 32'd0);
        chk("arst_memToRegW", 32'(memToRegW), 32'd0);
        chk("arst_ALUOutW", ALUOutW, 32'd0);
        chk("arst_writeRegW", 32'(writeRegW), 32'd0);
        chk("arst_memErr", 32'(memErr), 32'd0);
        idle_inputs();
        @(negedge clk); rstN = 1'b1;
        @(posedge clk); #1;
        wq.delete(); bq.delete();
        prevW = '{default: 0};
        errModel = 1'b0;
        active = 1'b1;
        run_instr(1, 0, 1, MEM_BYTE, 1, 32'h301, 32'h0, 32'h0000_F000, 5'd10, 2);
        run_instr(1, 0, 1, MEM_WORD, 0, 32'h304, 32'h0, 32'hCAFEF00D, 5'd11, 0);
        run_instr(0, 0, 0, MEM_WORD, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
        active = 1'b0;
        @(posedge clk); #1;

        chk("w_queue_drained", 32'(wq.size()), 32'd0);
        chk("bus_queue_drained", 32'(bq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage pipeline, directly upstream of the writeback stage.
- Issues load/store requests to the data memory through a req/ack handshake and holds the pipeline (stallM) while an access is outstanding.
- Performs byte/half/word lane steering and sign/zero extension.
- Registers the MEM/WB pipeline register (memToRegW, regWriteW, readDataW, ALUOutW, writeRegW) that feeds writeback.

Parameters:
- DATA_W, 32, datapath and memory data width.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum ack wait cycles before memErr is raised (1..1023).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- memToRegM  in  1  instruction is a load.
- regWriteM  in  1  instruction writes the register file.
- memWriteM  in  1  instruction is a store.
- memSizeM  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- loadUnsignedM  in  1  zero-extend (1) or sign-extend (0) sub-word loads.
- ALUOutM  in  DATA_W  effective address / ALU result.
- writeDataM  in  DATA_W  store data (right-aligned).
- writeRegM  in  5  destination register.
- memReq  out  1  memory request.
- memWe  out  1  write enable.
- memAddr  out  ADDR_W  word-aligned address (low 2 bits = 0).
- memBe  out  4  byte enables.
- memWData  out  DATA_W  lane-steered store data.
- memRData  in  DATA_W  read data, valid with memAck.
- memAck  in  1  access complete.
- stallM  out  1  freeze IF/ID/EX/MEM registers.
- alignErrM  out  1  one-cycle pulse on misaligned access.
- memErr  out  1  sticky timeout flag, cleared only by reset.
- memToRegW, regWriteW  out  1 each  MEM/WB control.
- readDataW, ALUOutW  out  DATA_W each  MEM/WB data.
- writeRegW  out  5  MEM/WB destination register.

Behaviour:
- Reset (rstN low, asynchronous): state IDLE; all outputs 0; timeout counter 0; memErr 0. Reset mid-access abandons the access, with memReq dropping immediately.
- Access: memToRegM or memWriteM set. A store with memToRegM also set is treated as a store.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - No request is issued; alignErrM pulses for one cycle.
  - The instruction passes to W as a bubble (regWriteW = 0); no stall.
- IDLE:
  - Aligned access → drive memReq = 1 combinationally in the same cycle. Address, be and data are derived from the M inputs.
  - If memAck is also high that cycle, the access completes with zero stall. Otherwise go to WAIT and assert stallM.
  - Non-access → pass-through, no stall.
- WAIT:
  - memReq, memWe, memAddr, memBe and memWData are held stable from registered copies.
  - stallM = 1 until the memAck cycle, then return to IDLE.
  - stallM is deasserted combinationally in the ack cycle, so the upstream registers advance on that edge.
- Timeout: counter increments every WAIT cycle.
  - On reaching TIMEOUT: set memErr, force completion (readData = 0), return to IDLE.
- Byte enables: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111. Store data is replicated into all lanes.
- Load extract: select the lane by addr[1:0]; sign- or zero-extend per loadUnsignedM. Word loads pass through unchanged.
- MEM/WB register:
  - Loads on each edge when stallM = 0, capturing the completing instruction.
  - While stallM = 1, a bubble is loaded: regWriteW = 0, memToRegW = 0, other W fields don't-care but held.
- Stores: regWriteW follows regWriteM (normally 0); memToRegW = 0.
- Non-load: readDataW holds its previous value. ALUOutW is always captured from ALUOutM.
- memAck while IDLE with no request is ignored.

Decomposition:
- Shared package pipe_pkg:
  - memSize encodings MEM_BYTE, MEM_HALF, MEM_WORD.
  - State enum IDLE/WAIT.
  - Register index width constant REG_IDX_W = 5.
- One sub-module, load_store_align: combinational byte-enable generation, store lane replication, load extraction/extension and misalignment detection.
- The FSM, timeout counter and MEM/WB register stay in memory_stage.

Test Plan:
- Word load, addr 0x100, memAck in the same cycle, memRData 0xDEADBEEF → memReq 1 for one cycle; stallM never 1; next cycle readDataW = 0xDEADBEEF, memToRegW = 1, regWriteW = 1.
- Signed byte load, addr 0x103, memRData 0x80000000, ack after 3 cycles → stallM high 3 cycles; memBe = 4'b1000; W bubbles (regWriteW = 0) during the stall; then readDataW = 0xFFFFFF80.
- Half store, addr 0x202, writeDataM 0x0000ABCD → memWe 1; memBe = 4'b1100; memWData = 0xABCDABCD; memAddr = 0x200; regWriteW = 0.
- Misaligned word load, addr 0x101 → no memReq; alignErrM single pulse; regWriteW = 0; stallM 0.
- TIMEOUT = 4, no ack → stallM high 4 cycles; memErr = 1 and stays; readDataW = 0; pipeline resumes.
- rstN low during WAIT → memReq and stallM drop immediately (asynchronous); all W outputs 0; next access after release behaves normally.
